// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory between the fetch port and the load/store port, with a watchdog abort.
// Optional wait-cycle counters are built when ARB_PERF_CNT_EN is defined; otherwise perf outputs are tied to 0.
module mem_port_arbiter #(
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       TIMEOUT = 64,
  parameter logic [DATA_W-1:0] IF_NOP  = 'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_err,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_d_wait
);

  localparam int unsigned WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

  state_t            state, state_next;
  logic              last_d;
  logic [WCNT_W-1:0] wcnt;
  logic              d_pend, i_pend;
  logic              grant_d, grant_i, ack_done, abort;

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = (d_rd | d_wr) & ~d_ready;

  // A request still high while its ready pulses is the finished access, not a new one.
  assign d_pend = stall_mem;
  assign i_pend = stall_if;

  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    ack_done   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (d_pend && (!i_pend || !last_d)) begin
          grant_d    = 1'b1;
          state_next = D_ACC;
        end else if (i_pend) begin
          grant_i    = 1'b1;
          state_next = I_ACC;
        end
      end
      D_ACC, I_ACC: begin
        if (m_ack) begin
          ack_done   = 1'b1;
          state_next = IDLE;
        end else if (TIMEOUT != 0 && wcnt == WCNT_MAX) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      wcnt     <= '0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_next;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      bus_err  <= 1'b0;
      if (grant_d) begin
        m_en    <= 1'b1;
        m_we    <= d_wr;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        last_d  <= 1'b1;
        wcnt    <= '0;
      end else if (grant_i) begin
        m_en   <= 1'b1;
        m_we   <= 1'b0;
        m_addr <= if_addr;
        last_d <= 1'b0;
        wcnt   <= '0;
      end else if (ack_done || abort) begin
        m_en <= 1'b0;
        m_we <= 1'b0;
      end else if (state != IDLE) begin
        wcnt <= wcnt + WCNT_W'(1);
      end
      // m_we still holds the latched op type during the completing cycle.
      if (ack_done || abort) begin
        bus_err <= abort;
        if (state == D_ACC) begin
          d_ready <= 1'b1;
          if (!m_we) d_rdata <= ack_done ? m_rdata : '0;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= ack_done ? m_rdata : IF_NOP;
        end
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_wait <= '0;
      perf_d_wait  <= '0;
    end else begin
      if (stall_if && perf_if_wait != '1) perf_if_wait <= perf_if_wait + 32'd1;
      if (stall_mem && perf_d_wait != '1) perf_d_wait <= perf_d_wait + 32'd1;
    end
  end
`else
  assign perf_if_wait = '0;
  assign perf_d_wait  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle vector table, directed corner sequences, randomized traffic vs a transaction model.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef ARB_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, d_rd, d_wr, m_ack;
  logic [AW-1:0] if_addr, d_addr, m_addr;
  logic [DW-1:0] d_wdata, m_rdata, if_rdata, d_rdata, m_wdata;
  logic          if_ready, d_ready, m_en, m_we, stall_if, stall_mem, bus_err;
  logic [31:0]   perf_if_wait, perf_d_wait;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .IF_NOP(NOP)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err),
    .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic ir; logic [31:0] ia; logic rd; logic wr; logic [31:0] da; logic [31:0] dw;
    logic ack; logic [31:0] mr;
    logic en; logic we; logic [31:0] ma; logic irdy; logic [31:0] ird;
    logic drdy; logic [31:0] drd; logic be; logic si; logic sm;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic ir, input logic [31:0] ia, input logic rd, input logic wr,
                              input logic [31:0] da, input logic [31:0] dw, input logic ack,
                              input logic [31:0] mr, input logic en, input logic we,
                              input logic [31:0] ma, input logic irdy, input logic [31:0] ird,
                              input logic drdy, input logic [31:0] drd, input logic be,
                              input logic si, input logic sm);
    vec_t v;
    v.ir = ir; v.ia = ia; v.rd = rd; v.wr = wr; v.da = da; v.dw = dw; v.ack = ack; v.mr = mr;
    v.en = en; v.we = we; v.ma = ma; v.irdy = irdy; v.ird = ird; v.drdy = drdy; v.drd = drd;
    v.be = be; v.si = si; v.sm = sm;
    vecs.push_back(v);
  endfunction

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    m_ack = 0; m_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // transaction-level reference: who owns the memory, what was latched, how long it has waited
  int          md_owner;   // 0 none, 1 data, 2 fetch
  logic [31:0] md_a, md_wd, md_ird, md_drd;
  logic        md_w, md_ri, md_rd, md_e;
  int          md_age;
  bit          fav_fetch;
  int unsigned p_if, p_d;
  bit          i_act, d_act;
  int          d_op;       // 0 load, 1 store, 2 both
  logic [31:0] i_a, d_a, d_w;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] F1, A, B, C, D;
    int en_cycles;
    bit got;

    F1 = 32'h0050_0093; A = 32'hAAAA_0001; B = 32'h1234_5678; C = 32'h0010_0073; D = 32'h0BAD_F00D;
    // zero-wait fetch
    add(1,'h10,0,0,0,0,0,0,          0,0,0,    0,0,    0,0, 0,1,0);
    add(1,'h10,0,0,0,0,1,F1,         1,0,'h10, 0,0,    0,0, 0,1,0);
    add(1,'h10,0,0,0,0,0,0,          0,0,0,    1,F1,   0,0, 0,0,0);
    add(0,0,0,0,0,0,0,0,             0,0,0,    0,F1,   0,0, 0,0,0);
    // contention with last_d=0: data first, then fetch
    add(1,'h40,1,0,'h200,0,0,0,      0,0,0,     0,F1,   0,0, 0,1,1);
    add(1,'h40,1,0,'h200,0,1,A,      1,0,'h200, 0,F1,   0,0, 0,1,1);
    add(1,'h40,1,0,'h200,0,0,0,      0,0,0,     0,F1,   1,A, 0,1,0);
    add(1,'h40,0,0,0,0,1,'h93,       1,0,'h40,  0,F1,   0,A, 0,1,0);
    add(1,'h40,0,0,0,0,0,0,          0,0,0,     1,'h93, 0,A, 0,0,0);
    // lone load sets last_d, then contention: fetch first, then data
    add(0,0,1,0,'h300,0,0,0,         0,0,0,     0,'h93, 0,A, 0,0,1);
    add(0,0,1,0,'h300,0,1,B,         1,0,'h300, 0,'h93, 0,A, 0,0,1);
    add(0,0,1,0,'h300,0,0,0,         0,0,0,     0,'h93, 1,B, 0,0,0);
    add(1,'h48,1,0,'h304,0,0,0,      0,0,0,     0,'h93, 0,B, 0,1,1);
    add(1,'h48,1,0,'h304,0,1,C,      1,0,'h48,  0,'h93, 0,B, 0,1,1);
    add(1,'h48,1,0,'h304,0,0,0,      0,0,0,     1,C,    0,B, 0,0,1);
    add(0,0,1,0,'h304,0,1,D,         1,0,'h304, 0,C,    0,B, 0,0,1);
    add(0,0,1,0,'h304,0,0,0,         0,0,0,     0,C,    1,D, 0,0,0);
    add(0,0,0,0,0,0,0,0,             0,0,0,     0,C,    0,D, 0,0,0);
    // store, 3 wait states; ack lands on the watchdog's last cycle and wins
    add(0,0,0,1,'h100,'hDEADBEEF,0,0,     0,0,0,     0,C, 0,D, 0,0,1);
    add(0,0,0,1,'h100,'hDEADBEEF,0,'h55,  1,1,'h100, 0,C, 0,D, 0,0,1);
    add(0,0,0,1,'h100,'hDEADBEEF,0,'h55,  1,1,'h100, 0,C, 0,D, 0,0,1);
    add(0,0,0,1,'h100,'hDEADBEEF,0,'h55,  1,1,'h100, 0,C, 0,D, 0,0,1);
    add(0,0,0,1,'h100,'hDEADBEEF,1,'h66,  1,1,'h100, 0,C, 0,D, 0,0,1);
    add(0,0,0,1,'h100,'hDEADBEEF,0,0,     0,0,0,     0,C, 1,D, 0,0,0);
    add(0,0,0,0,0,0,0,0,                  0,0,0,     0,C, 0,D, 0,0,0);

    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    chk("rst_m_en", m_en, 0);      chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);  chk("rst_m_wdata", m_wdata, 0);
    chk("rst_if_ready", if_ready, 0); chk("rst_d_ready", d_ready, 0);
    chk("rst_if_rdata", if_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_perf_if", perf_if_wait, 0); chk("rst_perf_d", perf_d_wait, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      if_req = vecs[i].ir; if_addr = vecs[i].ia; d_rd = vecs[i].rd; d_wr = vecs[i].wr;
      d_addr = vecs[i].da; d_wdata = vecs[i].dw; m_ack = vecs[i].ack; m_rdata = vecs[i].mr;
      @(negedge clk);
      chk($sformatf("v%0d_m_en", i), m_en, vecs[i].en);
      chk($sformatf("v%0d_m_we", i), m_we, vecs[i].we);
      if (vecs[i].en) chk($sformatf("v%0d_m_addr", i), m_addr, vecs[i].ma);
      chk($sformatf("v%0d_if_ready", i), if_ready, vecs[i].irdy);
      chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].ird);
      chk($sformatf("v%0d_d_ready", i), d_ready, vecs[i].drdy);
      chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].drd);
      chk($sformatf("v%0d_bus_err", i), bus_err, vecs[i].be);
      chk($sformatf("v%0d_stall_if", i), stall_if, vecs[i].si);
      chk($sformatf("v%0d_stall_mem", i), stall_mem, vecs[i].sm);
      @(posedge clk);
      #1;
    end

    // watchdog abort of a fetch; requester address wanders mid-access
    idle_inputs();
    if_req = 1; if_addr = 'h20;
    en_cycles = 0; got = 0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge clk);
      if (if_ready) begin
        got = 1;
        chk("to_en_cycles", en_cycles, 4);
        chk("to_bus_err", bus_err, 1);
        chk("to_if_rdata", if_rdata, NOP);
        chk("to_m_en", m_en, 0);
      end else if (m_en) begin
        en_cycles++;
        chk("to_m_addr", m_addr, 'h20);
        chk("to_no_err", bus_err, 0);
      end
      @(posedge clk);
      #1;
      if (m_en) if_addr = 'h999;
    end
    chk("to_completed", got, 1);
    idle_inputs();
    @(negedge clk);
    chk("to_err_pulse", bus_err, 0);
    chk("to_ready_pulse", if_ready, 0);
    @(posedge clk);
    #1;

    // reset while a load is in flight
    d_rd = 1; d_addr = 'h500;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rm_in_acc", m_en, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    d_rd = 0; m_ack = 1; m_rdata = 'hFEED_0001;
    @(negedge clk);
    chk("rm_m_en", m_en, 0); chk("rm_d_ready", d_ready, 0); chk("rm_d_rdata", d_rdata, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rm_late_ack_ready", d_ready, 0); chk("rm_late_ack_en", m_en, 0);
    @(posedge clk);
    #1 m_ack = 0; if_req = 1; if_addr = 'h60;
    @(negedge clk);
    chk("rm_f0_en", m_en, 0);
    @(posedge clk);
    #1 m_ack = 1; m_rdata = 'h00A0_0113;
    @(negedge clk);
    chk("rm_f1_en", m_en, 1); chk("rm_f1_addr", m_addr, 'h60);
    @(posedge clk);
    #1 m_ack = 0;
    @(negedge clk);
    chk("rm_f2_ready", if_ready, 1); chk("rm_f2_rdata", if_rdata, 'h00A0_0113);
    chk("rm_f2_err", bus_err, 0);
    @(posedge clk);
    #1 if_req = 0;

    // wait-cycle counters over a 3-wait store
    do_reset();
    d_wr = 1; d_addr = 'h100; d_wdata = 'hDEADBEEF;
    for (int c = 0; c < 7; c++) begin
      m_ack = (c == 4);
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        chk($sformatf("pc%0d_m_we", c), m_we, 1);
        chk($sformatf("pc%0d_m_wdata", c), m_wdata, 'hDEADBEEF);
      end
      if (c == 5) begin
        chk("pc_d_ready", d_ready, 1);
        chk("pc_d_rdata", d_rdata, 0);
      end
      if (c == 6) begin
        chk("pc_perf_d", perf_d_wait, PERF_ON ? 32'd5 : 32'd0);
        chk("pc_perf_if", perf_if_wait, 0);
      end
      @(posedge clk);
      #1;
      if (c == 5) d_wr = 0;
    end

    // randomized traffic against the model
    do_reset();
    md_owner = 0; md_a = 0; md_wd = 0; md_w = 0; md_age = 0;
    md_ird = 0; md_drd = 0; md_ri = 0; md_rd = 0; md_e = 0; fav_fetch = 0;
    p_if = 0; p_d = 0;
    i_act = 0; d_act = 0; d_op = 0; i_a = 0; d_a = 0; d_w = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic e_si, e_sm, n_ri, n_rd, n_e, wd, wi;
      if_req  = i_act;
      if_addr = (md_owner == 2) ? $urandom : i_a;
      d_rd    = d_act && d_op != 1;
      d_wr    = d_act && d_op != 0;
      d_addr  = (md_owner == 1) ? $urandom : d_a;
      d_wdata = (md_owner == 1) ? $urandom : d_w;
      m_ack   = ($urandom_range(0, 99) < 45);
      m_rdata = $urandom;
      e_si = i_act && !md_ri;
      e_sm = d_act && !md_rd;

      @(negedge clk);
      chk($sformatf("r%0d_m_en", cyc), m_en, md_owner != 0);
      chk($sformatf("r%0d_m_we", cyc), m_we, md_owner != 0 && md_w);
      if (md_owner != 0) chk($sformatf("r%0d_m_addr", cyc), m_addr, md_a);
      if (md_owner != 0 && md_w) chk($sformatf("r%0d_m_wdata", cyc), m_wdata, md_wd);
      chk($sformatf("r%0d_if_ready", cyc), if_ready, md_ri);
      chk($sformatf("r%0d_d_ready", cyc), d_ready, md_rd);
      chk($sformatf("r%0d_bus_err", cyc), bus_err, md_e);
      chk($sformatf("r%0d_if_rdata", cyc), if_rdata, md_ird);
      chk($sformatf("r%0d_d_rdata", cyc), d_rdata, md_drd);
      chk($sformatf("r%0d_stall_if", cyc), stall_if, e_si);
      chk($sformatf("r%0d_stall_mem", cyc), stall_mem, e_sm);

      n_ri = 0; n_rd = 0; n_e = 0;
      if (md_owner != 0) begin
        if (m_ack || md_age + 1 == int'(TO)) begin
          n_e = !m_ack;
          if (md_owner == 1) begin
            n_rd = 1;
            if (!md_w) md_drd = m_ack ? m_rdata : 32'h0;
          end else begin
            n_ri = 1;
            md_ird = m_ack ? m_rdata : NOP;
          end
          md_owner = 0;
        end else begin
          md_age++;
        end
      end else begin
        wd = d_act && !md_rd;
        wi = i_act && !md_ri;
        if (wd && (!wi || !fav_fetch)) begin
          md_owner = 1; md_a = d_a; md_w = (d_op != 0); md_wd = d_w; md_age = 0; fav_fetch = 1;
        end else if (wi) begin
          md_owner = 2; md_a = i_a; md_w = 0; md_age = 0; fav_fetch = 0;
        end
      end
      if (e_si) p_if++;
      if (e_sm) p_d++;

      if (i_act && md_ri) begin
        i_act = $urandom_range(0, 1);
        i_a = $urandom;
      end else if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1; i_a = $urandom;
      end
      if (d_act && md_rd) begin
        d_act = $urandom_range(0, 1);
        d_op = $urandom_range(0, 2); d_a = $urandom; d_w = $urandom;
      end else if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1; d_op = $urandom_range(0, 2); d_a = $urandom; d_w = $urandom;
      end
      md_ri = n_ri; md_rd = n_rd; md_e = n_e;

      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rand_perf_if", perf_if_wait, PERF_ON ? p_if : 32'd0);
    chk("rand_perf_d", perf_d_wait, PERF_ON ? p_d : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
